// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: operand width, RISC-V op encodings
// and a small sign helper used by the result fix-up.
package div_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [DATA_WIDTH-1:0] SIGN_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic neg,
                                                       input logic [DATA_WIDTH-1:0] val);
        return neg ? -val : val;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on
// operand magnitudes, sign fix-up at the end, and a registered register-file write.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [4:0]            rd_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  regfile_we_o,
    output logic [4:0]            regfile_waddr_o,
    output logic [DATA_WIDTH-1:0] regfile_data_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] CNT_FIRST = 5'd31;

    logic [1:0]            r_state;
    logic [4:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [4:0]            r_rd;
    logic                  r_is_rem;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_signed;
    logic                  w_is_rem;
    logic                  w_div0;
    logic                  w_ovf;
    logic                  w_special;
    logic                  w_rs1_neg;
    logic                  w_rs2_neg;
    logic [DATA_WIDTH-1:0] w_special_data;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_fit;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;
    logic [DATA_WIDTH-1:0] w_calc_data;
    logic [1:0]            w_next;
    logic [4:0]            w_fin_rd;
    logic [DATA_WIDTH-1:0] w_fin_data;

    // Request decode: special cases bypass CALC and finish one cycle after start.
    assign w_signed  = (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_is_rem  = (op_i == OP_REM) || (op_i == OP_REMU);
    assign w_div0    = (rs2_i == '0);
    assign w_ovf     = w_signed && (rs1_i == SIGN_MIN) && (rs2_i == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_rs1_neg = w_signed && rs1_i[DATA_WIDTH-1];
    assign w_rs2_neg = w_signed && rs2_i[DATA_WIDTH-1];
    assign w_special_data = w_div0 ? (w_is_rem ? rs1_i : '1)
                                   : (w_is_rem ? '0 : SIGN_MIN);

    // One restoring step: shift in the next dividend bit, keep the difference if it fits.
    assign w_rem_sh    = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_dvs};
    assign w_fit       = ~w_diff[DATA_WIDTH];
    assign w_rem_next  = w_fit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
    assign w_quo_next  = {r_quo[DATA_WIDTH-2:0], w_fit};
    assign w_calc_data = r_is_rem ? cond_neg(r_neg_r, w_rem_next)
                                  : cond_neg(r_neg_q, w_quo_next);

    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        w_next     = r_state;
        w_fin_rd   = '0;
        w_fin_data = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_special) begin
                        w_next     = S_DONE;
                        w_fin_rd   = rd_i;
                        w_fin_data = w_special_data;
                    end else begin
                        w_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next     = S_DONE;
                    w_fin_rd   = r_rd;
                    w_fin_data = w_calc_data;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_rd     <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start_i && !w_special) begin
                r_cnt    <= CNT_FIRST;
                r_quo    <= cond_neg(w_rs1_neg, rs1_i);
                r_rem    <= '0;
                r_dvs    <= cond_neg(w_rs2_neg, rs2_i);
                r_rd     <= rd_i;
                r_is_rem <= w_is_rem;
                r_neg_q  <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r  <= w_rs1_neg;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt - 5'd1;
                r_quo <= w_quo_next;
                r_rem <= w_rem_next;
            end
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            r_we    <= (w_next == S_DONE) && (w_fin_rd != '0);
            r_waddr <= w_fin_rd;
            r_data  <= w_fin_data;
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign regfile_we_o    = r_we;
    assign regfile_waddr_o = r_waddr;
    assign regfile_data_o  = r_data;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written
// start/reset sequences, and randomized ops against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start_i = 1'b0;
    logic [1:0]            op_i = '0;
    logic [DATA_WIDTH-1:0] rs1_i = '0;
    logic [DATA_WIDTH-1:0] rs2_i = '0;
    logic [4:0]            rd_i = '0;
    logic                  busy_o;
    logic                  done_o;
    logic                  regfile_we_o;
    logic [4:0]            regfile_waddr_o;
    logic [DATA_WIDTH-1:0] regfile_data_o;

    int n_pass  = 0;
    int n_total = 0;

    div_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .op_i            (op_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .rd_i            (rd_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .regfile_we_o    (regfile_we_o),
        .regfile_waddr_o (regfile_waddr_o),
        .regfile_data_o  (regfile_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else
            n_pass++;
    endtask

    // Reference: RISC-V division semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic is_rem;
        logic sgn;
        sa = a;
        sb = b;
        is_rem = (op == OP_REM) || (op == OP_REMU);
        sgn    = (op == OP_DIV) || (op == OP_REM);
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            if (is_rem) return sa % sb;
            return sa / sb;
        end
        if (is_rem) return a % b;
        return a / b;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic sgn;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Start in cycle 0, observe cycles 1..40; optional extra start pulses at cycles pa/pb.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int pa, input int pb,
                          output int cyc, output logic [31:0] data, output logic we,
                          output logic [4:0] waddr, output int n_done, output int n_busy,
                          output int n_stray);
        cyc = -1; data = '0; we = 1'b0; waddr = '0;
        n_done = 0; n_busy = 0; n_stray = 0;
        @(negedge clk);
        op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy_o) n_busy++;
            if (done_o) begin
                n_done++;
                cyc = c; data = regfile_data_o; we = regfile_we_o; waddr = regfile_waddr_o;
            end else if (regfile_we_o || regfile_waddr_o != 0 || regfile_data_o != 0) begin
                n_stray++;
            end
            start_i = (c == pa) || (c == pb);
            if (start_i) begin
                op_i = 2'($urandom); rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] exp_data, input int exp_cyc,
                            input int pa, input int pb);
        int cyc, n_done, n_busy, n_stray;
        logic [31:0] data;
        logic we;
        logic [4:0] waddr;
        run_op(op, a, b, rd, pa, pb, cyc, data, we, waddr, n_done, n_busy, n_stray);
        check({name, " cycle"}, 64'(cyc), 64'(exp_cyc));
        check({name, " data"}, 64'(data), 64'(exp_data));
        check({name, " we"}, 64'(we), 64'(rd != 0));
        check({name, " waddr"}, 64'(waddr), 64'(rd));
        check({name, " done pulses"}, 64'(n_done), 64'd1);
        check({name, " busy cycles"}, 64'(n_busy), 64'(exp_cyc));
        check({name, " idle outputs"}, 64'(n_stray), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " busy"}, 64'(busy_o), 64'd0);
        check({name, " done"}, 64'(done_o), 64'd0);
        check({name, " we"}, 64'(regfile_we_o), 64'd0);
        check({name, " waddr"}, 64'(regfile_waddr_o), 64'd0);
        check({name, " data"}, 64'(regfile_data_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_events;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  33};
        vecs[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1};
        vecs[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h0,          1};
        vecs[6]  = '{OP_DIVU, 32'd9,          32'd0,          5'd9,  32'hFFFF_FFFF,  1};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          5'd10, 32'd5,          1};
        vecs[8]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD,  33};
        vecs[9]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd12, 32'd1,          33};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};
        vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd1,          5'd13, 32'h8000_0000,  33};
        vecs[12] = '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          5'd14, 32'hFFFF_FFFF,  1};
        vecs[13] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd15, 32'hFFFF_FFFB,  1};
        vecs[14] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h0,          33};
        vecs[15] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  33};

        #3 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                     vecs[i].exp_data, vecs[i].exp_cyc, 0, 0);

        // Extra start pulses during CALC and DONE must not disturb the running op.
        check_op("restart ignored", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 5, 33);
        check_op("rd zero", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 33, 0, 0);

        // Reset asserted in cycle 10 of a normal op.
        @(negedge clk);
        op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd5; start_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        check("busy before abort", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_events = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o || regfile_we_o || busy_o) n_events++;
        end
        check("no write after abort", 64'(n_events), 64'd0);
        check_op("after abort", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom);
            case ($urandom_range(5, 0))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(15, 1));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            check_op($sformatf("rand%0d", i), rop, ra, rb, rrd,
                     ref_result(rop, ra, rb), ref_latency(rop, ra, rb), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_WIDTH (global define, not a module parameter), default 32, operand/result width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start_i  input  1  request; sampled only in IDLE.
REQ-005 Port: op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-006 Port: rs1_i  input  DATA_WIDTH  dividend.
REQ-007 Port: rs2_i  input  DATA_WIDTH  divisor.
REQ-008 Port: rd_i  input  5  destination register index.
REQ-009 Port: busy_o  output  1  high in CALC and DONE.
REQ-010 Port: done_o  output  1  one-cycle completion pulse.
REQ-011 Port: regfile_we_o  output  1  register-file write enable.
REQ-012 Port: regfile_waddr_o  output  5  write address.
REQ-013 Port: regfile_data_o  output  DATA_WIDTH  write data.

Function
REQ-014 FSM states: IDLE, CALC, DONE; one-hot or binary is an implementation choice.
REQ-015 IDLE->CALC on start_i=1 for normal operands; op, rd, sign flags and operand magnitudes are latched on that edge.
REQ-016 IDLE->DONE directly on start_i=1 when rs2_i=0 or on signed overflow (op DIV/REM, rs1_i=0x80000000, rs2_i=0xFFFFFFFF).
REQ-017 CALC: radix-2 restoring division on unsigned magnitudes, one quotient bit per cycle, 5-bit counter from 31 down to 0; CALC->DONE after exactly 32 CALC cycles.
REQ-018 Latency: start edge at cycle 0; DONE state (done_o=1) at cycle 33 for normal operands and cycle 1 for special cases.
REQ-019 DONE lasts exactly one cycle, then goes to IDLE unconditionally.
REQ-020 start_i is ignored in CALC and DONE; no queuing, and latched operands are not disturbed.
REQ-021 Sign fix-up for DIV: quotient negated when the operand signs differ. For REM: remainder takes the dividend's sign.
REQ-022 Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = rs1_i (REM and REMU).
REQ-023 Signed overflow: DIV result 0x80000000, REM result 0.
REQ-024 In DONE: done_o=1; regfile_waddr_o = latched rd; regfile_data_o = selected result; regfile_we_o=1 unless latched rd=0.
REQ-025 Outside DONE: done_o, regfile_we_o, regfile_waddr_o and regfile_data_o are all 0.
REQ-026 All outputs are driven from registers; there is no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 forces IDLE, clears the counter and all latched state, and drives every output to 0 immediately.
REQ-028 Reset during CALC or DONE aborts the operation; no write and no done_o pulse occur afterwards.

Structure
REQ-029 DATA_WIDTH and the DIV/DIVU/REM/REMU op encodings live in the shared defines header; no local redefinition.
REQ-030 Single module; no sub-module, because the datapath (subtractor, shift registers, negators) is small.

Verification
REQ-031 DIVU rs1=100, rs2=7, rd=5: done_o at cycle 33, we=1, waddr=5, data=14; REMU with the same operands gives 2.
REQ-032 DIV rs1=-7, rs2=2: data 0xFFFFFFFD (-3). REM with the same operands: data 0xFFFFFFFF (-1).
REQ-033 DIV 0x80000000 / 0xFFFFFFFF: done_o at cycle 1, data 0x80000000. DIVU 9/0: data 0xFFFFFFFF at cycle 1. REMU 5/0: data 5.
REQ-034 start_i pulsed again at cycles 5 and 33: ignored, and the first result is unchanged. rd=0: done_o=1, we=0.
REQ-035 rst_n low at cycle 10 of a normal op: outputs 0 at once, no we pulse afterwards, and a new start is accepted after release.
